bpsk_mod_src: RTL



---
 rtl/bpsk_mod_src.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/bpsk_mod_src.sv
// bpsk_mod_src: BPSK carrier source (NCO + quarter-wave sine LUT + symbol timing) for pll_top din.
// `define BPSK_DOPPLER_RAMP_EN adds fcw_step and a saturating per-symbol FCW ramp. Table is tabulated for LUT_AW = 8.
module bpsk_mod_src #(
    parameter int unsigned        PHASE_W  = 24,
    parameter int unsigned        DOUT_W   = 8,
    parameter int unsigned        LUT_AW   = 8,
    parameter int unsigned        SPB      = 16,
    parameter logic [PHASE_W-1:0] FCW_INIT = 24'h100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PHASE_W-1:0] fcw,
    input  logic               fcw_load,
`ifdef BPSK_DOPPLER_RAMP_EN
    input  logic [PHASE_W-1:0] fcw_step,
`endif
    input  logic               bit_data,
    input  logic               bit_valid,
    output logic               bit_ready,
    output logic [DOUT_W-1:0]  dout,
    output logic               dout_valid,
    output logic               bit_strobe,
    output logic               underrun
);

    localparam int unsigned CNT_W = $clog2(SPB);

    // round(127*sin(2*pi*k/256)) for k = 0..64; the other three quadrants come from symmetry
    localparam int QTAB [65] = '{
          0,   3,   6,   9,  12,  16,  19,  22,  25,  28,
         31,  34,  37,  40,  43,  46,  49,  51,  54,  57,
         60,  63,  65,  68,  71,  73,  76,  78,  81,  83,
         85,  88,  90,  92,  94,  96,  98, 100, 102, 104,
        106, 107, 109, 111, 112, 113, 115, 116, 117, 118,
        120, 121, 122, 122, 123, 124, 125, 125, 126, 126,
        126, 127, 127, 127, 127
    };

    function automatic logic signed [7:0] sine_lut(input logic [LUT_AW-1:0] a);
        logic [6:0] k;
        logic [7:0] mag;
        k   = a[LUT_AW-2] ? (7'd64 - {1'b0, a[LUT_AW-3 -: 6]}) : {1'b0, a[LUT_AW-3 -: 6]};
        mag = {1'b0, 7'(QTAB[k])};
        return a[LUT_AW-1] ? -$signed(mag) : $signed(mag);
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                    state, state_nx;
    logic [PHASE_W-1:0]        phase;
    logic [PHASE_W-1:0]        fcw_reg;
    logic [CNT_W-1:0]          sym_cnt;
    logic                      cur_bit;
    logic                      last;
    logic                      boundary;
    logic                      take;
    logic                      s0_valid;
    logic                      s0_strobe;
    logic [LUT_AW-1:0]         lut_addr;
    logic signed [7:0]         lut_q;
    logic                      neg_q;
    logic                      vld_q;
    logic                      stb_q;
    logic signed [DOUT_W-1:0]  sample;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        last     = (sym_cnt == CNT_W'(SPB - 1));
        state_nx = state;
        case (state)
            IDLE:    if (en && bit_valid) state_nx = RUN;
            RUN:     if (!en) state_nx = last ? IDLE : DRAIN;
            DRAIN:   if (last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        boundary  = en && ((state == IDLE) || ((state == RUN) && last));
        bit_ready = boundary && !rst;
        take      = boundary && bit_valid;
        underrun  = (state == RUN) && last && en && !bit_valid;
        s0_valid  = (state != IDLE);
        s0_strobe = s0_valid && (sym_cnt == '0);
    end

    // Phase is parked at zero while idle so every burst starts on phase 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase   <= '0;
            sym_cnt <= '0;
            cur_bit <= 1'b0;
        end else begin
            if ((state == IDLE) || (state_nx == IDLE)) phase <= '0;
            else                                       phase <= phase + fcw_reg;
            if ((state == IDLE) || last) sym_cnt <= '0;
            else                         sym_cnt <= sym_cnt + CNT_W'(1);
            if (take)          cur_bit <= bit_data;
            else if (underrun) cur_bit <= 1'b0;
        end
    end

`ifdef BPSK_DOPPLER_RAMP_EN
    logic signed [PHASE_W+1:0] fcw_sum;
    logic [PHASE_W-1:0]        fcw_ramp;

    always_comb begin
        fcw_sum = $signed({2'b00, fcw_reg}) + (PHASE_W+2)'($signed(fcw_step));
        if (fcw_sum[PHASE_W+1])  fcw_ramp = '0;
        else if (fcw_sum[PHASE_W]) fcw_ramp = '1;
        else                     fcw_ramp = fcw_sum[PHASE_W-1:0];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           fcw_reg <= FCW_INIT;
        else if (fcw_load) fcw_reg <= fcw;
`ifdef BPSK_DOPPLER_RAMP_EN
        else if ((state == RUN) && boundary) fcw_reg <= fcw_ramp;
`endif
    end

    always_comb begin
        lut_addr = phase[PHASE_W-1 -: LUT_AW];
        sample   = DOUT_W'(lut_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lut_q      <= '0;
            neg_q      <= 1'b0;
            vld_q      <= 1'b0;
            stb_q      <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            bit_strobe <= 1'b0;
        end else begin
            lut_q      <= sine_lut(lut_addr);
            neg_q      <= cur_bit;
            vld_q      <= s0_valid;
            stb_q      <= s0_strobe;
            dout       <= vld_q ? (neg_q ? -sample : sample) : '0;
            dout_valid <= vld_q;
            bit_strobe <= stb_q;
        end
    end

endmodule
